// File: rtl/byte_fifo_pkg.sv
// Shared constants for the byte path downstream of the CDC synchronizer.
// The data width is common with the synchronizer; the level width depends on FIFO depth.
package byte_fifo_pkg;

    localparam int DATA_W = 8;

    // Occupancy counter width: must represent 0..2**depth_log2 inclusive.
    function automatic int lvl_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through single-clock byte FIFO with valid/ready on both sides.
// iready_o and odata_o are driven only from registers, so no input-to-output paths exist.
module byte_fifo
    import byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
)
(
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [DATA_W-1:0]                idata_i,
    input  logic                             ivalid_i,
    output logic                             iready_o,
    output logic [DATA_W-1:0]                odata_o,
    output logic                             ovalid_o,
    input  logic                             oready_i,
    input  logic                             flush_i,
    output logic [lvl_w(DEPTH_LOG2)-1:0]     level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = lvl_w(DEPTH_LOG2);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_rdy_en;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);

    // r_rdy_en keeps the write side closed until the first edge after reset release.
    assign iready_o = r_rdy_en & ~w_full;
    assign ovalid_o = ~w_empty;
    assign odata_o  = r_mem[r_rd_ptr];
    assign level_o  = r_level;

    assign w_push   = ivalid_i & iready_o;
    assign w_pop    = ovalid_o & oready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (flush_i) begin
                // Storage is left as-is; only the bookkeeping is cleared.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= idata_i;
                    r_wr_ptr        <= r_wr_ptr + DEPTH_LOG2'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

endmodule
